// File: rtl/gpu_pkg.sv
// Types and constants shared between the command transmitter and the gpu block.
package gpu_pkg;

    typedef enum logic [1:0] {
        SIG_STORE_BYTE  = 2'b00,
        SIG_MOVE_CURSOR = 2'b01,
        SIG_DISPLAY     = 2'b10,
        SIG_CLEAR       = 2'b11
    } gpu_sig_t;

    localparam int TEXT_MODE_WIDTH  = 80;
    localparam int TEXT_MODE_HEIGHT = 60;

    // One FIFO entry: op in the top two bits, payload byte below.
    typedef struct packed {
        gpu_sig_t    op;
        logic [7:0]  data;
    } gpu_cmd_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/gpu_cmd_tx_if.sv
// Command handshake from the CPU I/O decode into the transmitter.
interface gpu_cmd_tx_if;
    import gpu_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    gpu_sig_t    cmd_op;
    logic [7:0]  cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_data, output cmd_ready);

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; count carries one extra bit so full and empty differ.
module cmd_fifo
    import gpu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  gpu_cmd_t                 din,
    output gpu_cmd_t                 dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    gpu_cmd_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gpu_cmd_tx.sv
// Replays buffered commands onto the gpu interrupt port with setup/pulse/hold timing.
//
//   state | meaning
//   IDLE  | waiting for a FIFO entry; pops and latches op/data
//   SETUP | op/data stable, strobe low
//   PULSE | strobe high (gpu samples on its rising edge)
//   HOLD  | strobe low, op/data still held; counts the command on exit
module gpu_cmd_tx
    import gpu_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    gpu_cmd_tx_if.slave                   cmd,
    output gpu_sig_t                      interrupt_out,
    output logic [7:0]                    data_out,
    output logic                          interrupt_enable_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   tx_count
);

    localparam int CNT_W = $clog2(max3(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES) + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    gpu_cmd_t         push_cmd;
    gpu_cmd_t         head;
    logic             full;
    logic             empty;
    logic             pop;

    assign push_cmd      = {cmd.cmd_op, cmd.cmd_data};
    assign cmd.cmd_ready = !full && !rst;
    assign pop           = (state == ST_IDLE) && !empty;
    assign busy          = !empty || (state != ST_IDLE);

    cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd.cmd_valid && cmd.cmd_ready),
        .pop   (pop),
        .din   (push_cmd),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // Sequencer: one shared down-counter times every non-idle state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= ST_IDLE;
            cnt                  <= '0;
            interrupt_out        <= SIG_STORE_BYTE;
            data_out             <= 8'h00;
            interrupt_enable_out <= 1'b0;
            tx_count             <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        interrupt_out <= head.op;
                        data_out      <= head.data;
                        cnt           <= CNT_W'(SETUP_CYCLES - 1);
                        state         <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        cnt                  <= CNT_W'(PULSE_CYCLES - 1);
                        interrupt_enable_out <= 1'b1;
                        state                <= ST_PULSE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        cnt                  <= CNT_W'(HOLD_CYCLES - 1);
                        interrupt_enable_out <= 1'b0;
                        state                <= ST_HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        tx_count <= tx_count + 16'd1;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    interrupt_enable_out <= 1'b0;
                    state                <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_cmd_tx.sv
// Scoreboard bench for gpu_cmd_tx: timing model from the command-period rules, plus a small gpu model.
module tb_gpu_cmd_tx;
    import gpu_pkg::*;

    localparam int S     = 2;
    localparam int P     = 2;
    localparam int H     = 2;
    localparam int PER   = 1 + S + P + H;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    gpu_cmd_tx_if cmd_if();
    gpu_cmd_tx_if fast_if();

    gpu_sig_t    int_out;
    logic [7:0]  data_out;
    logic        strobe;
    logic        busy;
    logic [3:0]  fifo_count;
    logic [15:0] tx_count;

    gpu_sig_t    f_int_out;
    logic [7:0]  f_data_out;
    logic        f_strobe;
    logic        f_busy;
    logic [3:0]  f_fifo_count;
    logic [15:0] f_tx_count;

    gpu_cmd_tx #(.FIFO_DEPTH(DEPTH), .SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H)) u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .cmd                  (cmd_if),
        .interrupt_out        (int_out),
        .data_out             (data_out),
        .interrupt_enable_out (strobe),
        .busy                 (busy),
        .fifo_count           (fifo_count),
        .tx_count             (tx_count)
    );

    gpu_cmd_tx #(.FIFO_DEPTH(8), .SETUP_CYCLES(1), .PULSE_CYCLES(1), .HOLD_CYCLES(1)) u_fast (
        .clk                  (clk),
        .rst                  (rst),
        .cmd                  (fast_if),
        .interrupt_out        (f_int_out),
        .data_out             (f_data_out),
        .interrupt_enable_out (f_strobe),
        .busy                 (f_busy),
        .fifo_count           (f_fifo_count),
        .tx_count             (f_tx_count)
    );

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endfunction

    // Reference model: each accepted command gets its pop edge from the period rule.
    typedef struct {
        gpu_sig_t   op;
        logic [7:0] data;
        int         push_e;
        int         pop_e;
    } exp_t;

    exp_t hist[$];
    exp_t sb[$];
    int   last_pop = -1000;

    // Behavioural gpu fed by the strobe.
    logic [7:0] glyph [TEXT_MODE_WIDTH*TEXT_MODE_HEIGHT];
    int gx = 0;
    int gy = 0;
    bit swapped = 1'b0;

    function automatic void gpu_apply(input gpu_sig_t op, input logic [7:0] d);
        case (op)
            SIG_MOVE_CURSOR: begin
                if (d[7]) gx = (gx + int'(d[6:0])) % TEXT_MODE_WIDTH;
                else      gy = (gy + int'(d[5:0])) % TEXT_MODE_HEIGHT;
            end
            SIG_STORE_BYTE: begin
                glyph[gy*TEXT_MODE_WIDTH + gx] = d;
                gx = (gx + 1) % TEXT_MODE_WIDTH;
            end
            SIG_DISPLAY: swapped = !swapped;
            default: ;
        endcase
    endfunction

    // Monitor for the default-timing instance.
    bit prev = 1'b0;
    always @(negedge clk) begin
        int mc, mt, li;
        bit mb, ms;
        exp_t e;
        if (rst) begin
            chk("ready_in_rst", 32'(cmd_if.cmd_ready), 0);
            if (rst_q) begin
                chk("rst_strobe", 32'(strobe), 0);
                chk("rst_fifo_count", 32'(fifo_count), 0);
                chk("rst_tx_count", 32'(tx_count), 0);
                chk("rst_data_out", 32'(data_out), 0);
                chk("rst_int_out", 32'(int_out), 0);
                chk("rst_busy", 32'(busy), 0);
            end
            prev = 1'b0;
        end else begin
            mc = 0; mt = 0; li = -1; mb = 1'b0; ms = 1'b0;
            foreach (hist[i]) begin
                if (hist[i].push_e <= cyc && hist[i].pop_e > cyc) mc++;
                if (hist[i].push_e <= cyc && cyc < hist[i].pop_e + PER - 1) mb = 1'b1;
                if (hist[i].pop_e + PER - 1 <= cyc) mt++;
                if (cyc >= hist[i].pop_e + S && cyc < hist[i].pop_e + S + P) ms = 1'b1;
                if (hist[i].pop_e <= cyc) li = i;
            end
            chk("fifo_count", 32'(fifo_count), 32'(mc));
            chk("cmd_ready", 32'(cmd_if.cmd_ready), 32'(mc < DEPTH));
            chk("busy", 32'(busy), 32'(mb));
            chk("tx_count", 32'(tx_count), 32'(mt));
            chk("strobe", 32'(strobe), 32'(ms));
            if (li >= 0) begin
                chk("data_hold", 32'(data_out), 32'(hist[li].data));
                chk("op_hold", 32'(int_out), 32'(hist[li].op));
            end else begin
                chk("data_idle", 32'(data_out), 0);
                chk("op_idle", 32'(int_out), 0);
            end
            if (strobe && !prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rise_op", 32'(int_out), 32'(e.op));
                    chk("rise_data", 32'(data_out), 32'(e.data));
                    chk("rise_cycle", 32'(cyc), 32'(e.pop_e + S));
                end
                gpu_apply(int_out, data_out);
            end
            prev = strobe;
        end
    end

    // Monitor for the 1/1/1 timing instance: order, payload and 4-cycle period.
    gpu_cmd_t fq[$];
    bit f_prev = 1'b0;
    int f_last_rise = -1;
    always @(negedge clk) begin
        gpu_cmd_t fe;
        if (rst) begin
            f_prev = 1'b0;
        end else begin
            if (f_strobe && !f_prev) begin
                if (fq.size() == 0) begin
                    chk("fast_unexpected_strobe", 1, 0);
                end else begin
                    fe = fq.pop_front();
                    chk("fast_op", 32'(f_int_out), 32'(fe.op));
                    chk("fast_data", 32'(f_data_out), 32'(fe.data));
                    if (f_last_rise >= 0)
                        chk("fast_period", 32'(cyc - f_last_rise), 4);
                    f_last_rise = cyc;
                end
            end
            f_prev = f_strobe;
        end
    end

    task automatic send(input gpu_sig_t op, input logic [7:0] d);
        int w, n, p;
        exp_t e;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = d;
        w = 0;
        forever begin
            @(negedge clk);
            if (cmd_if.cmd_ready === 1'b1) begin
                n = cyc + 1;
                p = (n + 1 > last_pop + PER) ? n + 1 : last_pop + PER;
                last_pop = p;
                e = '{op: op, data: d, push_e: n, pop_e: p};
                hist.push_back(e);
                sb.push_back(e);
                @(posedge clk); #1;
                break;
            end
            w++;
            if (w > 100) begin
                chk("send_timeout", 32'(w), 0);
                @(posedge clk); #1;
                break;
            end
        end
    endtask

    task automatic send_fast(input gpu_sig_t op, input logic [7:0] d);
        int w;
        fast_if.cmd_valid = 1'b1;
        fast_if.cmd_op    = op;
        fast_if.cmd_data  = d;
        w = 0;
        forever begin
            @(negedge clk);
            if (fast_if.cmd_ready === 1'b1) begin
                fq.push_back({op, d});
                @(posedge clk); #1;
                break;
            end
            w++;
            if (w > 100) begin
                chk("fast_send_timeout", 32'(w), 0);
                @(posedge clk); #1;
                break;
            end
        end
    endtask

    task automatic idle();
        cmd_if.cmd_valid  = 1'b0;
        fast_if.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        idle();
        for (k = 0; k < 1000; k++) begin
            if (cyc > last_pop + PER) break;
            @(posedge clk); #1;
        end
        if (k >= 1000) chk("drain_timeout", 32'(k), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hist.delete();
        sb.delete();
        fq.delete();
        last_pop = -1000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_rand();
        send(gpu_sig_t'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    endtask

    initial begin
        int base, target, k;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_op     = SIG_STORE_BYTE;
        cmd_if.cmd_data   = 8'h00;
        fast_if.cmd_valid = 1'b0;
        fast_if.cmd_op    = SIG_STORE_BYTE;
        fast_if.cmd_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // single command
        send(SIG_STORE_BYTE, 8'h41);
        drain();

        // eight back-to-back with valid held
        for (int i = 0; i < 8; i++) send_rand();
        drain();

        // ten back-to-back: fills the FIFO behind the first command
        for (int i = 0; i < 10; i++) send_rand();
        drain();

        // random traffic with gaps
        for (int i = 0; i < 30; i++) begin
            send_rand();
            if ($urandom_range(0, 2) == 0) begin
                idle();
                repeat ($urandom_range(1, 9)) @(posedge clk);
                #1;
            end
        end
        drain();

        // reset during PULSE of the third of five
        base = hist.size();
        for (int i = 0; i < 5; i++) send_rand();
        idle();
        target = hist[base + 2].pop_e + S;
        for (k = 0; k < 200; k++) begin
            if (cyc >= target) break;
            @(posedge clk); #1;
        end
        if (k >= 200) chk("pulse_wait_timeout", 32'(k), 0);
        chk("strobe_before_rst", 32'(strobe), 1);
        do_reset();
        send(SIG_CLEAR, 8'h5A);
        drain();

        // loopback into the gpu model
        gx = 0; gy = 0; swapped = 1'b0;
        send(SIG_MOVE_CURSOR, 8'h85);
        send(SIG_STORE_BYTE, 8'h41);
        send(SIG_DISPLAY, 8'h00);
        drain();
        chk("gpu_cursor_x", 32'(gx), 6);
        chk("gpu_cursor_y", 32'(gy), 0);
        chk("gpu_glyph_5_0", 32'(glyph[5]), 32'h41);
        chk("gpu_swapped", 32'(swapped), 1);

        // short timing instance
        f_last_rise = -1;
        for (int i = 0; i < 6; i++)
            send_fast(gpu_sig_t'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        idle();
        repeat (40) @(posedge clk);
        #1;
        chk("fast_tx_count", 32'(f_tx_count), 6);
        chk("fast_fifo_count", 32'(f_fifo_count), 0);
        chk("fast_busy", 32'(f_busy), 0);
        chk("fast_all_seen", 32'(fq.size()), 0);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
